rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter ROM_CAPACITY, default 4096: ROM depth in bytes, which is also the write-address range.
REQ-002 Parameter ACK_TIMEOUT, default 64: number of cycles a write may wait for ack before the block aborts.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle pulse requesting a load; sampled only in IDLE.
REQ-006 last_addr  input  12  final ROM address to write (bytes loaded = last_addr+1); sampled with start.
REQ-007 in_data  input  8  program byte stream.
REQ-008 in_valid / in_ready  input / output  1  stream handshake; a transfer occurs when both are high on a rising edge.
REQ-009 wb_addr_o, wb_data_o  output  32  Wishbone write address (zero-extended) and data ({24'b0, byte}).
REQ-010 wb_cyc_o, wb_strobe_o, wb_we_o  output  1  Wishbone master controls; all three assert together.
REQ-011 wb_ack_i  input  1  ROM backdoor acknowledge.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse on successful completion.
REQ-014 error  output  1  sticky ack-timeout flag.
REQ-015 cpu_hold  output  1  holds the CPU in reset; high while busy or error.

Function
REQ-016 FSM states: IDLE, FETCH, WRITE, FINISH.
REQ-017 IDLE with start=1: latch last_addr, clear the address counter to 0, clear error, go to FETCH.
REQ-018 A start pulse outside IDLE shall be ignored.
REQ-019 FETCH: in_ready=1; on handshake, latch in_data, go to WRITE.
REQ-020 WRITE: cyc, strobe and we are high with registered address and data; they are held stable until wb_ack_i.
REQ-021 On ack in WRITE: if addr==last_addr go to FINISH, else addr+1 and go to FETCH.
REQ-022 Bus signals drop the cycle after ack; no back-to-back strobe.
REQ-023 Minimum cost is 2 cycles per byte plus ack latency (the ROM acks only in subcycle 7, so up to 8 extra cycles).
REQ-024 Timeout counter clears on WRITE entry and increments each WRITE cycle without ack.
REQ-025 When the timeout counter reaches ACK_TIMEOUT-1: set error, drop the bus signals, return to IDLE; done is not pulsed.
REQ-026 FINISH lasts one cycle: done=1, then IDLE; cpu_hold falls on IDLE entry when error=0.
REQ-027 Ack outside WRITE shall be ignored.
REQ-028 in_valid outside FETCH shall not be consumed.
REQ-029 last_addr>=ROM_CAPACITY: the address is truncated to $clog2(ROM_CAPACITY) bits and wraps, matching ROM indexing.
REQ-030 last_addr=0 loads exactly one byte.

Reset
REQ-031 Reset shall force IDLE, addr=0, timeout counter=0, in_ready=0, all wb_*_o=0, busy=0, done=0, error=0, cpu_hold=0, regardless of state.
REQ-032 Reset during WRITE drops cyc/strobe immediately (asynchronously).

Configuration
REQ-033 With ROM_LOADER_CHECKSUM_EN defined: add output checksum[7:0], the mod-256 sum of bytes acked in the current load; cleared on an accepted start; reset value 0.
REQ-034 Without ROM_LOADER_CHECKSUM_EN: the checksum port and its logic are absent; all other behaviour is identical.

Structure
REQ-035 Shared package holds the FSM state encoding, the default ACK_TIMEOUT and the ROM_CAPACITY default constant.
REQ-036 Single flat module; no sub-module.

Verification
REQ-037 last_addr=3, bytes A0,A1,A2,A3 streamed, ROM model acking at subcycle 7 -> ROM[0..3]=A0..A3, one done pulse, cpu_hold low after.
REQ-038 in_valid gapped 5 cycles between bytes -> no Wishbone strobe without a fresh byte; addresses strictly 0,1,2.
REQ-039 Ack withheld at addr 2, ACK_TIMEOUT=64 -> error=1 on cycle 63 of WRITE, bus idle, no done, cpu_hold stays 1; the next start clears error.
REQ-040 start pulsed mid-load -> ignored; load completes normally.
REQ-041 Reset asserted during WRITE -> cyc=0 without a clock edge, all outputs at reset values.
REQ-042 Checksum build, bytes 80,90,10 -> checksum=20 at done.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// Shared types and default constants for the ROM loader.
package rom_loader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StWrite,
        StFinish
    } state_e;

    localparam int unsigned RomCapacityDefault = 4096;
    localparam int unsigned AckTimeoutDefault  = 64;
    localparam int unsigned LastAddrWidth      = 12;

endpackage

// File: rtl/rom_loader_if.sv
// Wishbone write-only backdoor bus between the ROM loader (master) and the ROM (slave).
interface rom_loader_if;

    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic        wb_cyc_o;
    logic        wb_strobe_o;
    logic        wb_we_o;
    logic        wb_ack_i;

    modport master (
        output wb_addr_o, wb_data_o, wb_cyc_o, wb_strobe_o, wb_we_o,
        input  wb_ack_i
    );

    modport slave (
        input  wb_addr_o, wb_data_o, wb_cyc_o, wb_strobe_o, wb_we_o,
        output wb_ack_i
    );

endinterface

// File: rtl/rom_loader.sv
// Streams program bytes into a ROM over a Wishbone backdoor while holding the CPU in reset.
// Define ROM_LOADER_CHECKSUM_EN to add a mod-256 checksum output of acked bytes.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int unsigned ROM_CAPACITY = RomCapacityDefault,
    parameter int unsigned ACK_TIMEOUT  = AckTimeoutDefault
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LastAddrWidth-1:0] last_addr,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    rom_loader_if.master             wb,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic                     cpu_hold
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]               checksum
`endif
);

    localparam int unsigned TmoW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    // Count runs on the full last_addr width; only the bus address wraps to the ROM depth.
    localparam logic [LastAddrWidth-1:0] AddrMask =
        LastAddrWidth'((1 << $clog2(ROM_CAPACITY)) - 1);

    state_e                   state_q, state_d;
    logic [LastAddrWidth-1:0] addr_q, addr_d;
    logic [LastAddrWidth-1:0] last_q, last_d;
    logic [7:0]               data_q, data_d;
    logic [TmoW-1:0]          tmo_q, tmo_d;
    logic                     error_q, error_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            last_q  <= '0;
            data_q  <= '0;
            tmo_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        data_d  = data_q;
        tmo_d   = tmo_q;
        error_d = error_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    last_d  = last_addr;
                    addr_d  = '0;
                    error_d = 1'b0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (in_valid) begin
                    data_d  = in_data;
                    tmo_d   = '0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (wb.wb_ack_i) begin
                    if (addr_q == last_q) begin
                        state_d = StFinish;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = StFetch;
                    end
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                    // Counter is about to reach ACK_TIMEOUT-1: abort this edge.
                    if (tmo_q == TmoW'(ACK_TIMEOUT - 2)) begin
                        error_d = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Bus controls decode straight from the state register so reset drops them at once.
    assign wb.wb_cyc_o    = (state_q == StWrite);
    assign wb.wb_strobe_o = (state_q == StWrite);
    assign wb.wb_we_o     = (state_q == StWrite);
    assign wb.wb_addr_o   = 32'(addr_q & AddrMask);
    assign wb.wb_data_o   = {24'b0, data_q};

    assign in_ready = (state_q == StFetch);
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StFinish);
    assign error    = error_q;
    assign cpu_hold = (state_q != StIdle) | error_q;

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            csum_q <= '0;
        end else if (state_q == StIdle && start) begin
            csum_q <= '0;
        end else if (state_q == StWrite && wb.wb_ack_i) begin
            csum_q <= csum_q + data_q;
        end
    end

    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: ROM slave acking in subcycle 7, randomized byte streams.
module tb_rom_loader;

    localparam int unsigned Cap = 16;
    localparam int unsigned Tmo = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [11:0] last_addr = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, busy, done, error, cpu_hold;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]  checksum;
    logic [7:0]  csum_snap = '0;
`endif

    rom_loader_if wb_bus ();

    rom_loader #(
        .ROM_CAPACITY(Cap),
        .ACK_TIMEOUT (Tmo)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .last_addr(last_addr),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wb       (wb_bus),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_hold (cpu_hold)
`ifdef ROM_LOADER_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    always #5 clock = ~clock;

    // ROM slave: acks only in subcycle 7 of a free-running 8-cycle frame.
    logic [2:0] sub = '0;
    bit         ack_en = 1'b1;
    bit         force_ack = 1'b0;
    int         blk_addr = -1;

    assign wb_bus.wb_ack_i = force_ack ||
        (ack_en && wb_bus.wb_cyc_o && wb_bus.wb_strobe_o && sub == 3'd7 &&
         int'(wb_bus.wb_addr_o) != blk_addr);

    logic [7:0] rom [Cap];
    int         wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         hs_cnt = 0, entry_cnt = 0, done_cnt = 0, bb_viol = 0;
    logic       prev_cyc = 1'b0, prev_ack = 1'b0;

    always @(posedge clock) begin
        sub <= sub + 3'd1;
        if (!reset) begin
            if (in_valid && in_ready) hs_cnt <= hs_cnt + 1;
            if (wb_bus.wb_cyc_o && !prev_cyc) entry_cnt <= entry_cnt + 1;
            if (prev_ack && wb_bus.wb_cyc_o) bb_viol <= bb_viol + 1;
            if (wb_bus.wb_cyc_o && wb_bus.wb_strobe_o && wb_bus.wb_we_o && wb_bus.wb_ack_i) begin
                rom[wb_bus.wb_addr_o[3:0]] <= wb_bus.wb_data_o[7:0];
                wr_addr_q.push_back(int'(wb_bus.wb_addr_o));
                wr_data_q.push_back(wb_bus.wb_data_o[7:0]);
            end
            if (done) done_cnt <= done_cnt + 1;
        end
        prev_cyc <= wb_bus.wb_cyc_o;
        prev_ack <= wb_bus.wb_ack_i && wb_bus.wb_cyc_o;
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] payload [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int la);
        start     = 1'b1;
        last_addr = 12'(la);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            if (done) begin
                seen = 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
                csum_snap = checksum;
`endif
            end else begin
                @(negedge clock);
            end
        end
    endtask

    // Reference: byte i lands at address i mod Cap, exactly last+1 writes, one done pulse.
    task automatic do_load(input int last, input int gap, input int poke_at, input string tag);
        bit         seen;
        int         base_wr   = wr_addr_q.size();
        int         base_hs   = hs_cnt;
        int         base_en   = entry_cnt;
        int         base_done = done_cnt;
        int         first;
        logic [7:0] sum = '0;
        pulse_start(last);
        chk({tag, "_err_clr"}, 32'(error), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i <= last; i++) begin
            if (i == poke_at) pulse_start(0);
            repeat (gap) @(negedge clock);
            send_byte(payload[i]);
            sum = sum + payload[i];
        end
        wait_done(seen);
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clock);
        chk({tag, "_nwrites"}, 32'(wr_addr_q.size() - base_wr), 32'(last + 1));
        for (int i = 0; i <= last; i++) begin
            if (base_wr + i < wr_addr_q.size()) begin
                chk({tag, "_waddr"}, 32'(wr_addr_q[base_wr + i]), 32'(i % Cap));
                chk({tag, "_wdata"}, 32'(wr_data_q[base_wr + i]), 32'(payload[i]));
            end
        end
        first = (last + 1 > int'(Cap)) ? last + 1 - int'(Cap) : 0;
        for (int i = first; i <= last; i++) begin
            chk({tag, "_rom"}, 32'(rom[i % Cap]), 32'(payload[i]));
        end
        chk({tag, "_hs"}, 32'(hs_cnt - base_hs), 32'(last + 1));
        chk({tag, "_strobes"}, 32'(entry_cnt - base_en), 32'(last + 1));
        chk({tag, "_done_cnt"}, 32'(done_cnt - base_done), 32'd1);
        chk({tag, "_b2b"}, 32'(bb_viol), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_hold_after"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_error_after"}, 32'(error), 32'd0);
`ifdef ROM_LOADER_CHECKSUM_EN
        chk({tag, "_csum"}, 32'(csum_snap), 32'(sum));
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         cnt;
        int         base_wr, base_hs, base_done;
        bit         seen;

        // Asynchronous reset before any clock edge.
        #1 reset = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_cyc", 32'(wb_bus.wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_bus.wb_strobe_o), 32'd0);
        chk("rst_we", 32'(wb_bus.wb_we_o), 32'd0);
        chk("rst_addr", wb_bus.wb_addr_o, 32'd0);
        chk("rst_data", wb_bus.wb_data_o, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // in_valid in IDLE must not be consumed.
        base_hs  = hs_cnt;
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (4) begin
            chk("idle_in_ready", 32'(in_ready), 32'd0);
            @(negedge clock);
        end
        in_valid = 1'b0;
        chk("idle_no_hs", 32'(hs_cnt - base_hs), 32'd0);

        // Four-byte directed load.
        payload[0] = 8'hA0; payload[1] = 8'hA1; payload[2] = 8'hA2; payload[3] = 8'hA3;
        do_load(3, 0, -1, "basic");

        // Gapped stream with ack asserted outside WRITE as well.
        for (int i = 0; i < 3; i++) payload[i] = 8'($urandom);
        force_ack = 1'b1;
        do_load(2, 5, -1, "gapped");
        force_ack = 1'b0;

        // Start pulsed mid-load is ignored.
        for (int i = 0; i < 6; i++) payload[i] = 8'($urandom);
        do_load(5, 1, 2, "midstart");

        // Randomized loads, first one a single byte.
        for (int k = 0; k < 6; k++) begin
            int la;
            la = (k == 0) ? 0 : int'($urandom_range(0, 14));
            for (int i = 0; i <= la; i++) payload[i] = 8'($urandom);
            do_load(la, int'($urandom_range(0, 3)), -1, "rand");
        end

        // last_addr beyond ROM depth: addresses wrap.
        for (int i = 0; i < 20; i++) payload[i] = 8'($urandom);
        do_load(19, 0, -1, "wrap");

        // Ack withheld at address 2: abort after ACK_TIMEOUT-1 WRITE cycles.
        blk_addr  = 2;
        base_wr   = wr_addr_q.size();
        base_done = done_cnt;
        pulse_start(3);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        cnt = 0;
        for (int n = 0; n < 200 && !error; n++) begin
            if (wb_bus.wb_cyc_o) cnt++;
            @(negedge clock);
        end
        chk("tmo_cycles", 32'(cnt), 32'(Tmo - 1));
        chk("tmo_error", 32'(error), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_cyc", 32'(wb_bus.wb_cyc_o), 32'd0);
        chk("tmo_hold", 32'(cpu_hold), 32'd1);
        repeat (3) @(negedge clock);
        chk("tmo_hold_sticky", 32'(cpu_hold), 32'd1);
        chk("tmo_no_done", 32'(done_cnt - base_done), 32'd0);
        chk("tmo_writes", 32'(wr_addr_q.size() - base_wr), 32'd2);
        blk_addr = -1;
        payload[0] = 8'h3C; payload[1] = 8'hC3;
        do_load(1, 0, -1, "recover");

`ifdef ROM_LOADER_CHECKSUM_EN
        payload[0] = 8'h80; payload[1] = 8'h90; payload[2] = 8'h10;
        do_load(2, 0, -1, "csum");
        chk("csum_const", 32'(csum_snap), 32'h20);
`endif

        // Reset mid-WRITE drops the bus without a clock edge.
        ack_en = 1'b0;
        pulse_start(3);
        send_byte(8'h77);
        chk("pre_rst_cyc", 32'(wb_bus.wb_cyc_o), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_cyc", 32'(wb_bus.wb_cyc_o), 32'd0);
        chk("arst_stb", 32'(wb_bus.wb_strobe_o), 32'd0);
        chk("arst_we", 32'(wb_bus.wb_we_o), 32'd0);
        chk("arst_data", wb_bus.wb_data_o, 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_hold", 32'(cpu_hold), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clock);
        reset  = 1'b0;
        ack_en = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 3; i++) payload[i] = 8'($urandom);
        do_load(2, 0, -1, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
